// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug run/step controller.
package dbg_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALT    = 2'd1,
        STEP    = 2'd2,
        CAPTURE = 2'd3
    } dbg_state_t;

    // 10 ms at 50 MHz
    localparam int DBG_DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter.
module debouncer
    import dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DBG_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // any sample that agrees with the current level restarts the count
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug run/halt/single-step controller: gates the pipeline clock enable and
// holds a stable PC and step count for the seven-segment display stage.
module dbg_step_ctrl
    import dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DBG_DEBOUNCE_DEFAULT,
    parameter int PC_W            = 32,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_sw,
    input  logic             step_btn,
    input  logic [PC_W-1:0]  pc_in,
    output logic             cpu_en,
    output logic             debug,
    output logic [PC_W-1:0]  pc_hold,
    output logic [CNT_W-1:0] step_count
);

    dbg_state_t       state, next_state;
    logic             mode_lvl, step_lvl, step_prev, step_rise;
    logic             cpu_en_nxt, debug_nxt;
    logic [PC_W-1:0]  pc_hold_nxt;
    logic [CNT_W-1:0] step_count_nxt;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (mode_sw),
        .level (mode_lvl)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (step_btn),
        .level (step_lvl)
    );

    assign step_rise = step_lvl & ~step_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            step_prev  <= 1'b0;
            cpu_en     <= 1'b1;
            debug      <= 1'b0;
            pc_hold    <= '0;
            step_count <= '0;
        end else begin
            state      <= next_state;
            step_prev  <= step_lvl;
            cpu_en     <= cpu_en_nxt;
            debug      <= debug_nxt;
            pc_hold    <= pc_hold_nxt;
            step_count <= step_count_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (mode_lvl) next_state = HALT;
            // leaving debug mode beats a simultaneous step press
            HALT:    if (!mode_lvl) next_state = RUN;
                     else if (step_rise) next_state = STEP;
            STEP:    next_state = CAPTURE;
            CAPTURE: next_state = mode_lvl ? HALT : RUN;
            default: next_state = RUN;
        endcase
    end

    // Outputs are decoded from next_state so they line up with the state register.
    always_comb begin
        cpu_en_nxt     = (next_state == RUN) || (next_state == STEP);
        debug_nxt      = (next_state != RUN);
        pc_hold_nxt    = pc_hold;
        step_count_nxt = step_count;
        if (state == RUN || state == CAPTURE) pc_hold_nxt = pc_in;
        if (state == CAPTURE) step_count_nxt = step_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Bench for dbg_step_ctrl: directed scenarios plus randomized switch/button
// activity checked against a sample-window reference model.
module tb_dbg_step_ctrl;

    localparam int D = 4;
    localparam int P_RUN = 0, P_HALT = 1, P_STEP = 2, P_CAP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        cpu_en, debug;
    logic [31:0] pc_hold;
    logic [15:0] step_count;

    int n_cmp = 0;
    int n_err = 0;

    dbg_step_ctrl #(.DEBOUNCE_CYCLES(D), .PC_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_sw    (mode_sw),
        .step_btn   (step_btn),
        .pc_in      (pc_in),
        .cpu_en     (cpu_en),
        .debug      (debug),
        .pc_hold    (pc_hold),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Reference model: a debounced level flips once the D synchronized samples
    // in its window all disagree with it; the window lags raw by two samples.
    int          m_phase = P_RUN;
    bit          m_cpu_en = 1'b1, m_dbg = 1'b0;
    logic [31:0] m_hold = '0;
    logic [15:0] m_cnt = '0;
    bit          m_mode_lvl = 1'b0, m_step_lvl = 1'b0, m_step_prev = 1'b0;
    bit          mode_hist[$];
    bit          step_hist[$];

    function automatic bit settle(bit lvl, bit h[$]);
        for (int i = 2; i < D + 2; i++)
            if (h[i] == lvl) return lvl;
        return ~lvl;
    endfunction

    task automatic model_edge();
        bit rise;
        int nxt;
        if (rst) begin
            m_phase = P_RUN; m_cpu_en = 1'b1; m_dbg = 1'b0; m_hold = '0; m_cnt = '0;
            m_mode_lvl = 1'b0; m_step_lvl = 1'b0; m_step_prev = 1'b0;
            mode_hist.delete(); step_hist.delete();
            for (int i = 0; i < D + 2; i++) begin
                mode_hist.push_back(1'b0);
                step_hist.push_back(1'b0);
            end
        end else begin
            rise = m_step_lvl & ~m_step_prev;
            nxt  = m_phase;
            case (m_phase)
                P_RUN:  begin m_hold = pc_in; if (m_mode_lvl) nxt = P_HALT; end
                P_HALT: if (!m_mode_lvl) nxt = P_RUN; else if (rise) nxt = P_STEP;
                P_STEP: nxt = P_CAP;
                default: begin
                    m_hold = pc_in;
                    m_cnt  = m_cnt + 16'd1;
                    nxt    = m_mode_lvl ? P_HALT : P_RUN;
                end
            endcase
            m_phase     = nxt;
            m_cpu_en    = (nxt == P_RUN) || (nxt == P_STEP);
            m_dbg       = (nxt != P_RUN);
            m_step_prev = m_step_lvl;
            mode_hist.push_front(mode_sw);  void'(mode_hist.pop_back());
            step_hist.push_front(step_btn); void'(step_hist.pop_back());
            m_mode_lvl = settle(m_mode_lvl, mode_hist);
            m_step_lvl = settle(m_step_lvl, step_hist);
        end
    endtask

    // One clock: model follows the edge, pipeline PC advances while enabled.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_cpu_en) pc_in = pc_in + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_sw = 1'b0; step_btn = 1'b0;
        tick(); tick();
        n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL reset_cpu_en: got %0b want 1", cpu_en); end
        n_cmp++; if (debug !== 1'b0) begin n_err++; $display("FAIL reset_debug: got %0b want 0", debug); end
        n_cmp++; if (pc_hold !== 32'd0) begin n_err++; $display("FAIL reset_pc_hold: got %h want 0", pc_hold); end
        n_cmp++; if (step_count !== 16'd0) begin n_err++; $display("FAIL reset_step_count: got %h want 0", step_count); end
    endtask

    task automatic test_run();
        logic [31:0] prev;
        rst = 1'b0; pc_in = 32'd0;
        for (int i = 0; i < 10; i++) begin
            prev = pc_in;
            tick();
            n_cmp++; if (pc_hold !== prev || cpu_en !== 1'b1 || debug !== 1'b0) begin
                n_err++; $display("FAIL run_follow: pc_hold %h cpu_en %0b debug %0b want %h 1 0", pc_hold, cpu_en, debug, prev);
            end
        end
    endtask

    task automatic test_halt_entry();
        pc_in = 32'h28; mode_sw = 1'b1;
        for (int i = 0; i < D + 2; i++) tick();
        n_cmp++; if (debug !== 1'b0 || cpu_en !== 1'b1) begin
            n_err++; $display("FAIL halt_early: debug %0b cpu_en %0b want 0 1", debug, cpu_en);
        end
        tick();
        n_cmp++; if (debug !== 1'b1 || cpu_en !== 1'b0) begin
            n_err++; $display("FAIL halt_entry: debug %0b cpu_en %0b want 1 0", debug, cpu_en);
        end
        n_cmp++; if (pc_hold !== 32'h40) begin n_err++; $display("FAIL halt_pc: got %h want 00000040", pc_hold); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (pc_hold !== 32'h40 || cpu_en !== 1'b0) begin
            n_err++; $display("FAIL halt_frozen: pc_hold %h cpu_en %0b want 00000040 0", pc_hold, cpu_en);
        end
    endtask

    task automatic test_step();
        int pulses = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); pulses += int'(cpu_en); end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); pulses += int'(cpu_en); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL step_pulses: got %0d want 1", pulses); end
        n_cmp++; if (pc_hold !== 32'h44) begin n_err++; $display("FAIL step_pc: got %h want 00000044", pc_hold); end
        n_cmp++; if (step_count !== 16'd1) begin n_err++; $display("FAIL step_count: got %h want 0001", step_count); end
        n_cmp++; if (debug !== 1'b1 || cpu_en !== 1'b0) begin
            n_err++; $display("FAIL step_rehalt: debug %0b cpu_en %0b want 1 0", debug, cpu_en);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        logic [31:0] hold0 = pc_hold;
        pc_in = pc_in ^ 32'h1000_0000;
        step_btn = 1'b1;
        for (int i = 0; i < D - 1; i++) begin tick(); pulses += int'(cpu_en); end
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); pulses += int'(cpu_en); end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
        n_cmp++; if (step_count !== 16'd1) begin n_err++; $display("FAIL glitch_count: got %h want 0001", step_count); end
        n_cmp++; if (pc_hold !== hold0) begin n_err++; $display("FAIL glitch_pc: got %h want %h", pc_hold, hold0); end
    endtask

    task automatic test_race();
        int halted_pulse = 0;
        mode_sw = 1'b0; step_btn = 1'b1;
        for (int i = 0; i < D + 6; i++) begin tick(); if (debug && cpu_en) halted_pulse++; end
        n_cmp++; if (halted_pulse != 0) begin n_err++; $display("FAIL race_step: got %0d step cycles want 0", halted_pulse); end
        n_cmp++; if (debug !== 1'b0 || cpu_en !== 1'b1) begin
            n_err++; $display("FAIL race_run: debug %0b cpu_en %0b want 0 1", debug, cpu_en);
        end
        n_cmp++; if (step_count !== 16'd1) begin n_err++; $display("FAIL race_count: got %h want 0001", step_count); end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_release_during_step();
        int step_cycles = 0;
        mode_sw = 1'b1;
        for (int i = 0; i < D + 4; i++) tick();
        n_cmp++; if (debug !== 1'b1) begin n_err++; $display("FAIL rel_halt: debug %0b want 1", debug); end
        step_btn = 1'b1;
        tick();
        mode_sw = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (debug && cpu_en) step_cycles++; end
        n_cmp++; if (step_cycles != 1) begin n_err++; $display("FAIL rel_step: got %0d step cycles want 1", step_cycles); end
        n_cmp++; if (step_count !== 16'd2) begin n_err++; $display("FAIL rel_count: got %h want 0002", step_count); end
        n_cmp++; if (debug !== 1'b0 || cpu_en !== 1'b1) begin
            n_err++; $display("FAIL rel_run: debug %0b cpu_en %0b want 0 1", debug, cpu_en);
        end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_wrap();
        mode_sw = 1'b1;
        for (int i = 0; i < D + 4; i++) tick();
        force dut.step_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        tick();
        release dut.step_count;
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (step_count !== 16'h0000) begin n_err++; $display("FAIL wrap_count: got %h want 0000", step_count); end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_rst_in_step();
        bit found = 1'b0;
        step_btn = 1'b1;
        for (int i = 0; i < 16 && !found; i++) begin tick(); if (debug && cpu_en) found = 1'b1; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL rst_step_reach: got no step cycle want one"); end
        rst = 1'b1; mode_sw = 1'b0; step_btn = 1'b0;
        tick();
        n_cmp++; if (cpu_en !== 1'b1 || debug !== 1'b0) begin
            n_err++; $display("FAIL rst_step_state: cpu_en %0b debug %0b want 1 0", cpu_en, debug);
        end
        n_cmp++; if (step_count !== 16'd0 || pc_hold !== 32'd0) begin
            n_err++; $display("FAIL rst_step_regs: count %h pc_hold %h want 0000 00000000", step_count, pc_hold);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5, 0) == 0) mode_sw = ~mode_sw;
            if ($urandom_range(3, 0) == 0) step_btn = ~step_btn;
            if ($urandom_range(31, 0) == 0) pc_in = $urandom & 32'hFFFF_FFFC;
            rst = ($urandom_range(299, 0) == 0);
            tick();
            n_cmp++; if (cpu_en !== m_cpu_en) begin n_err++; $display("FAIL rand_cpu_en @%0d: got %0b want %0b", i, cpu_en, m_cpu_en); end
            n_cmp++; if (debug !== m_dbg) begin n_err++; $display("FAIL rand_debug @%0d: got %0b want %0b", i, debug, m_dbg); end
            n_cmp++; if (pc_hold !== m_hold) begin n_err++; $display("FAIL rand_pc_hold @%0d: got %h want %h", i, pc_hold, m_hold); end
            n_cmp++; if (step_count !== m_cnt) begin n_err++; $display("FAIL rand_count @%0d: got %h want %h", i, step_count, m_cnt); end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_run();
        test_halt_entry();
        test_step();
        test_glitch();
        test_race();
        test_release_during_step();
        test_wrap();
        test_rst_in_step();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
